fir_coeff_loader: RTL and testbench

- Runtime writer for the FIR processing-element coefficient RAMs. The existing initram flow fills these RAMs only at elaboration; this block reloads them while the design is running.
- Accepts one AXI-stream frame of NPE*NTAPS coefficient words and converts it into per-PE RAM write strobes.
- Sits beside top_fir and drives each gen_pe[i] coefficient RAM write port, so the RAM contents can be read back exactly as the PE0..PE3 tap dumps are today.

---
 rtl/fir_coeff_loader_if.sv | 12 +
 rtl/fir_coeff_loader.sv | 110 +++++++++++
 tb/tb_fir_coeff_loader.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_coeff_loader_if.sv
// AXI-stream channel that carries coefficient words into fir_coeff_loader.
interface fir_coeff_loader_if #(
    parameter int unsigned WIDTH = 16
);
    logic [WIDTH-1:0] tdata;
    logic             tvalid;
    logic             tready;
    logic             tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/fir_coeff_loader.sv
// Runtime coefficient loader: turns one AXI-stream frame of NPE*NTAPS words into
// one-hot per-PE coefficient RAM write strobes, with framing-error detection.
module fir_coeff_loader #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NTAPS = 8,
    parameter int unsigned NPE   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    fir_coeff_loader_if.slave        s_axis_coeff,
    output logic [NPE-1:0]           coeff_wen,
    output logic [$clog2(NTAPS)-1:0] coeff_waddr,
    output logic [WIDTH-1:0]         coeff_wdata,
    output logic                     load_done,
    output logic                     load_err,
    output logic                     busy
);
    localparam int unsigned TapW = $clog2(NTAPS);
    localparam int unsigned PeW  = (NPE > 1) ? $clog2(NPE) : 1;
    localparam logic [TapW-1:0] LastTap = TapW'(NTAPS - 1);
    localparam logic [PeW-1:0]  LastPe  = PeW'(NPE - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StDrain, StCommit} state_e;

    state_e          state_q;
    logic            tready_q;
    logic [TapW-1:0] tap_cnt_q;
    logic [PeW-1:0]  pe_cnt_q;
    logic            accept;
    logic            last_word;

    assign s_axis_coeff.tready = tready_q;
    assign accept    = s_axis_coeff.tvalid & tready_q;
    assign last_word = (tap_cnt_q == LastTap) && (pe_cnt_q == LastPe);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            tready_q    <= 1'b0;
            tap_cnt_q   <= '0;
            pe_cnt_q    <= '0;
            coeff_wen   <= '0;
            coeff_waddr <= '0;
            coeff_wdata <= '0;
            load_done   <= 1'b0;
            load_err    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            coeff_wen <= '0;
            load_done <= 1'b0;
            load_err  <= 1'b0;

            unique case (state_q)
                // Idle and Load share word handling; in Idle the counters are at word 0.
                StIdle, StLoad: begin
                    tready_q <= 1'b1;
                    if (accept) begin
                        if (s_axis_coeff.tlast && !last_word) begin
                            // Early tlast: drop this word, keep whatever was already written.
                            load_err  <= 1'b1;
                            busy      <= 1'b0;
                            tap_cnt_q <= '0;
                            pe_cnt_q  <= '0;
                            state_q   <= StIdle;
                        end else begin
                            coeff_wen   <= NPE'(1) << pe_cnt_q;
                            coeff_waddr <= tap_cnt_q;
                            coeff_wdata <= s_axis_coeff.tdata;
                            busy        <= 1'b1;
                            if (last_word) begin
                                tap_cnt_q <= '0;
                                pe_cnt_q  <= '0;
                                if (s_axis_coeff.tlast) begin
                                    load_done <= 1'b1;
                                    tready_q  <= 1'b0;
                                    state_q   <= StCommit;
                                end else begin
                                    state_q <= StDrain;
                                end
                            end else begin
                                if (tap_cnt_q == LastTap) begin
                                    tap_cnt_q <= '0;
                                    pe_cnt_q  <= pe_cnt_q + 1'b1;
                                end else begin
                                    tap_cnt_q <= tap_cnt_q + 1'b1;
                                end
                                state_q <= StLoad;
                            end
                        end
                    end
                end

                StDrain: begin
                    tready_q <= 1'b1;
                    if (accept && s_axis_coeff.tlast) begin
                        load_err <= 1'b1;
                        busy     <= 1'b0;
                        state_q  <= StIdle;
                    end
                end

                StCommit: begin
                    tready_q <= 1'b1;
                    busy     <= 1'b0;
                    state_q  <= StIdle;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fir_coeff_loader.sv
// Self-checking bench for fir_coeff_loader: frame-level reference model, scenario
// table, and hand-written reset / back-to-back sequences.
module tb_fir_coeff_loader;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned NTAPS = 8;
    localparam int unsigned NPE   = 4;
    localparam int unsigned N     = NPE * NTAPS;
    localparam int unsigned AW    = $clog2(NTAPS);

    logic             clk;
    logic             rst;
    logic [NPE-1:0]   coeff_wen;
    logic [AW-1:0]    coeff_waddr;
    logic [WIDTH-1:0] coeff_wdata;
    logic             load_done;
    logic             load_err;
    logic             busy;

    fir_coeff_loader_if #(.WIDTH(WIDTH)) s_if ();

    fir_coeff_loader #(.WIDTH(WIDTH), .NTAPS(NTAPS), .NPE(NPE)) dut (
        .clk         (clk),
        .rst         (rst),
        .s_axis_coeff(s_if),
        .coeff_wen   (coeff_wen),
        .coeff_waddr (coeff_waddr),
        .coeff_wdata (coeff_wdata),
        .load_done   (load_done),
        .load_err    (load_err),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Observed DUT activity and the RAM image built from the DUT's write port.
    int n_writes, n_done, n_err, n_tready_low;
    logic [WIDTH-1:0] ram_act [N];
    logic [WIDTH-1:0] ram_exp [N];

    // Reference model: k = index of the next word within the current frame.
    int               m_k;
    bit               m_drain, m_busy, m_commit;
    logic             exp_tready;
    logic [NPE-1:0]   exp_wen;
    logic [AW-1:0]    exp_waddr;
    logic [WIDTH-1:0] exp_wdata;
    logic             exp_done, exp_err;

    typedef struct {
        int          nwords;
        int          tlast_at;
        int          gap_pct;
        logic [15:0] base;     // 0 selects random data
        int          exp_writes;
        int          exp_done;
        int          exp_err;
    } row_t;

    row_t rows [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    function automatic void model_reset();
        m_k = 0; m_drain = 0; m_busy = 0; m_commit = 0;
        exp_tready = 1'b0;
    endfunction

    function automatic void model_step(input bit acc, input logic [WIDTH-1:0] d, input bit l);
        exp_wen = '0; exp_done = 0; exp_err = 0; exp_tready = 1'b1;
        if (m_commit) begin
            m_commit = 0;
            m_busy   = 0;
        end
        if (acc) begin
            if (m_drain) begin
                if (l) begin
                    exp_err = 1; m_drain = 0; m_busy = 0;
                end
            end else if (l && m_k < N - 1) begin
                exp_err = 1; m_k = 0; m_busy = 0;
            end else begin
                exp_wen   = NPE'(1 << (m_k / NTAPS));
                exp_waddr = AW'(m_k % NTAPS);
                exp_wdata = d;
                ram_exp[m_k] = d;
                m_busy = 1;
                if (m_k == N - 1) begin
                    m_k = 0;
                    if (l) begin
                        exp_done = 1; exp_tready = 1'b0; m_commit = 1;
                    end else begin
                        m_drain = 1;
                    end
                end else begin
                    m_k++;
                end
            end
        end
    endfunction

    // One clock: drive at the negedge, advance the model, check outputs at the next negedge.
    task automatic cycle(input logic v, input logic [WIDTH-1:0] d, input logic l, output bit acc);
        s_if.tvalid = v;
        s_if.tdata  = d;
        s_if.tlast  = l;
        chk("tready", 32'(s_if.tready), 32'(exp_tready));
        if (!s_if.tready) n_tready_low++;
        acc = v && exp_tready;
        model_step(acc, d, l);
        @(negedge clk);
        chk("wen", 32'(coeff_wen), 32'(exp_wen));
        if (exp_wen != '0) begin
            chk("waddr", 32'(coeff_waddr), 32'(exp_waddr));
            chk("wdata", 32'(coeff_wdata), 32'(exp_wdata));
        end
        chk("load_done", 32'(load_done), 32'(exp_done));
        chk("load_err", 32'(load_err), 32'(exp_err));
        chk("busy", 32'(busy), 32'(m_busy || m_drain));
        chk("done_err_excl", 32'(load_done & load_err), 32'd0);
        if (coeff_wen != '0) n_writes++;
        for (int p = 0; p < NPE; p++)
            if (coeff_wen[p]) ram_act[p * NTAPS + int'(coeff_waddr)] = coeff_wdata;
        if (load_done) n_done++;
        if (load_err) n_err++;
    endtask

    task automatic idle(input int n);
        bit acc;
        repeat (n) cycle(1'b0, '0, 1'b0, acc);
    endtask

    task automatic send_words(input int nwords, input int tlast_at, input int gap_pct,
                              input logic [15:0] base);
        bit acc;
        logic [WIDTH-1:0] d;
        for (int w = 0; w < nwords; w++) begin
            d = (base == 16'h0) ? WIDTH'($urandom) : WIDTH'(base + 16'(w));
            acc = 0;
            for (int t = 0; t < 200 && !acc; t++)
                cycle(($urandom_range(99) >= gap_pct), d, (w == tlast_at), acc);
            if (!acc) begin
                chk("handshake_timeout", 32'd0, 32'd1);
                return;
            end
        end
    endtask

    task automatic check_ram(input string tag);
        for (int i = 0; i < N; i++) chk({tag, "_ram"}, 32'(ram_act[i]), 32'(ram_exp[i]));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_tready"}, 32'(s_if.tready), 32'd0);
        chk({tag, "_wen"}, 32'(coeff_wen), 32'd0);
        chk({tag, "_waddr"}, 32'(coeff_waddr), 32'd0);
        chk({tag, "_wdata"}, 32'(coeff_wdata), 32'd0);
        chk({tag, "_done"}, 32'(load_done), 32'd0);
        chk({tag, "_err"}, 32'(load_err), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic clear_counts();
        n_writes = 0; n_done = 0; n_err = 0; n_tready_low = 0;
    endtask

    initial begin
        rows[0] = '{32, 31, 0,  16'h1000, 32, 1, 0};
        rows[1] = '{32, 31, 50, 16'h1000, 32, 1, 0};
        rows[2] = '{11, 10, 0,  16'h2000, 10, 0, 1};
        rows[3] = '{32, 31, 0,  16'h1100, 32, 1, 0};
        rows[4] = '{35, 34, 0,  16'h3000, 32, 0, 1};
        rows[5] = '{32, 31, 30, 16'h0000, 32, 1, 0};

        for (int i = 0; i < N; i++) begin
            ram_act[i] = '0;
            ram_exp[i] = '0;
        end
        exp_wen = '0; exp_waddr = '0; exp_wdata = '0; exp_done = 0; exp_err = 0;
        clear_counts();
        model_reset();

        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;

        for (int r = 0; r < 6; r++) begin
            clear_counts();
            send_words(rows[r].nwords, rows[r].tlast_at, rows[r].gap_pct, rows[r].base);
            idle(3);
            chk($sformatf("row%0d_writes", r), 32'(n_writes), 32'(rows[r].exp_writes));
            chk($sformatf("row%0d_done", r), 32'(n_done), 32'(rows[r].exp_done));
            chk($sformatf("row%0d_err", r), 32'(n_err), 32'(rows[r].exp_err));
            check_ram($sformatf("row%0d", r));
            if (r == 0) chk("readback_pe2_tap3", 32'(ram_act[2 * NTAPS + 3]), 32'h1013);
        end

        // Reset in the middle of a frame, with a write strobe currently on the outputs.
        clear_counts();
        send_words(17, -1, 0, 16'h7000);
        #2 rst = 1'b0;
        s_if.tvalid = 1'b0;
        #1 check_all_zero("midreset");
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        clear_counts();
        send_words(32, 31, 0, 16'h4000);
        idle(3);
        chk("postreset_writes", 32'(n_writes), 32'd32);
        chk("postreset_done", 32'(n_done), 32'd1);
        chk("postreset_err", 32'(n_err), 32'd0);
        chk("postreset_pe0_tap0", 32'(ram_act[0]), 32'h4000);
        check_ram("postreset");

        // Two frames back to back with tvalid held high.
        clear_counts();
        send_words(32, 31, 0, 16'h5000);
        n_tready_low = 0;
        send_words(32, 31, 0, 16'h6000);
        chk("b2b_bubble", 32'(n_tready_low), 32'd1);
        idle(3);
        chk("b2b_done", 32'(n_done), 32'd2);
        chk("b2b_writes", 32'(n_writes), 32'd64);
        chk("b2b_last_word", 32'(ram_act[N - 1]), 32'h601F);
        check_ram("b2b");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
